// File: rtl/dtcm_ctrl_pkg.sv
// Shared configuration for the DTCM controller: data width, address width and SRAM depth.
package dtcm_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int DTCM_ADDR_WIDTH = 16;
  localparam int DTCM_RAM_DP     = 1024;
  localparam int RSP_FIFO_DEPTH  = 2;

endpackage

// File: rtl/dtcm_ram.sv
// Synchronous single-port SRAM with per-byte write enables and a 1-cycle registered read.
module dtcm_ram #(
  parameter int DW = 32,
  parameter int DP = 1024,
  parameter int IW = $clog2(DP)
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] wmask,
  input  logic [IW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DP];

  // NOTE: the storage array has no reset, so it maps onto an SRAM macro and keeps its contents across rst.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++) begin
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dtcm_ctrl.sv
// LSU-to-DTCM responder: 1-cycle SRAM access plus a 2-entry in-order response buffer.
// Optional `DTCM_ADDR_CHK_EN adds range checking and the dtcm_rsp_err port; otherwise addresses wrap.
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW     = XLEN,
  parameter int AW     = DTCM_ADDR_WIDTH,
  parameter int RAM_DP = DTCM_RAM_DP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dtcm_cmd_valid,
  output logic            dtcm_cmd_ready,
  input  logic            dtcm_cmd_read,
  input  logic [AW-1:0]   dtcm_cmd_addr,
  input  logic [DW-1:0]   dtcm_cmd_wdata,
  input  logic [DW/8-1:0] dtcm_cmd_wmask,
  output logic            dtcm_rsp_valid,
  input  logic            dtcm_rsp_ready,
  output logic [DW-1:0]   dtcm_rsp_rdata
`ifdef DTCM_ADDR_CHK_EN
  ,
  output logic            dtcm_rsp_err
`endif
);

  localparam int IW = $clog2(RAM_DP);
  localparam int WW = AW - 2;

  logic          accept;
  logic [WW-1:0] word_idx;
  logic [IW-1:0] ram_addr;
  logic          in_range;
  logic [DW-1:0] ram_rdata;

  logic          inflight;
  logic          inflight_read;
  logic          inflight_err;
  logic [DW-1:0] inflight_rdata;

  logic [DW-1:0] fifo_rdata [RSP_FIFO_DEPTH];
  logic          fifo_err   [RSP_FIFO_DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          head_err;
  logic          unused_bits;

  assign word_idx = dtcm_cmd_addr[AW-1:2];
  // Upper index bits are dropped: RAM_DP is a power of two, so this is the modulo wrap.
  assign ram_addr = word_idx[IW-1:0];

`ifdef DTCM_ADDR_CHK_EN
  assign in_range = (word_idx[WW-1:IW] == '0);
`else
  assign in_range = 1'b1;
`endif

  // Occupancy counts the buffered responses plus the one coming out of the SRAM.
  assign dtcm_cmd_ready = (count == 2'd0) || ((count == 2'd1) && !inflight);
  assign accept         = dtcm_cmd_valid && dtcm_cmd_ready && !rst;

  dtcm_ram #(
    .DW (DW),
    .DP (RAM_DP),
    .IW (IW)
  ) u_ram (
    .clk   (clk),
    .en    (accept && in_range),
    .we    (!dtcm_cmd_read),
    .wmask (dtcm_cmd_wmask),
    .addr  (ram_addr),
    .wdata (dtcm_cmd_wdata),
    .rdata (ram_rdata)
  );

  // Writes and rejected reads answer with zero data; the SRAM register is only valid after a read.
  assign inflight_rdata = (inflight && inflight_read && !inflight_err) ? ram_rdata : '0;

  assign fifo_empty     = (count == 2'd0);
  assign dtcm_rsp_valid = !fifo_empty || inflight;
  assign dtcm_rsp_rdata = fifo_empty ? inflight_rdata : fifo_rdata[rd_ptr];
  assign head_err       = fifo_empty ? (inflight && inflight_err) : fifo_err[rd_ptr];

  assign pop  = !fifo_empty && dtcm_rsp_ready;
  // The inflight result bypasses the buffer only when nothing older is queued and it is taken now.
  assign push = inflight && !(fifo_empty && dtcm_rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_read <= 1'b0;
      inflight_err  <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      inflight      <= accept;
      inflight_read <= dtcm_cmd_read;
      inflight_err  <= !in_range;
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= inflight_rdata;
      fifo_err[wr_ptr]   <= inflight_err;
    end
  end

`ifdef DTCM_ADDR_CHK_EN
  assign dtcm_rsp_err = head_err;
`endif

  assign unused_bits = ^{dtcm_cmd_addr[1:0], word_idx, head_err};

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Self-checking bench for dtcm_ctrl: queue-based response model plus directed literal scenarios.
`timescale 1ns/1ps
module tb_dtcm_ctrl;
  import dtcm_ctrl_pkg::*;

  localparam int DW = XLEN;
  localparam int AW = DTCM_ADDR_WIDTH;
  localparam int DP = DTCM_RAM_DP;
`ifdef DTCM_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            dtcm_cmd_valid;
  logic            dtcm_cmd_ready;
  logic            dtcm_cmd_read;
  logic [AW-1:0]   dtcm_cmd_addr;
  logic [DW-1:0]   dtcm_cmd_wdata;
  logic [DW/8-1:0] dtcm_cmd_wmask;
  logic            dtcm_rsp_valid;
  logic            dtcm_rsp_ready;
  logic [DW-1:0]   dtcm_rsp_rdata;
`ifdef DTCM_ADDR_CHK_EN
  logic            dtcm_rsp_err;
`endif

  always #5 clk = ~clk;

  dtcm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .dtcm_cmd_valid (dtcm_cmd_valid),
    .dtcm_cmd_ready (dtcm_cmd_ready),
    .dtcm_cmd_read  (dtcm_cmd_read),
    .dtcm_cmd_addr  (dtcm_cmd_addr),
    .dtcm_cmd_wdata (dtcm_cmd_wdata),
    .dtcm_cmd_wmask (dtcm_cmd_wmask),
    .dtcm_rsp_valid (dtcm_rsp_valid),
    .dtcm_rsp_ready (dtcm_rsp_ready),
    .dtcm_rsp_rdata (dtcm_rsp_rdata)
`ifdef DTCM_ADDR_CHK_EN
    ,
    .dtcm_rsp_err   (dtcm_rsp_err)
`endif
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int          checks   = 0;
  int          failures = 0;
  bit          chk_on   = 1'b0;
  rsp_t        exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] mem_m [DP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted command owes exactly one response; its payload is fixed at acceptance time.
  function automatic void model_accept(input logic rd, input logic [AW-1:0] a,
                                       input logic [31:0] wd, input logic [3:0] wm);
    int   widx;
    bit   oob;
    int   w;
    rsp_t r;
    widx    = int'(a[AW-1:2]);
    oob     = CHK && (widx >= DP);
    w       = widx % DP;
    r.err   = oob;
    r.rdata = '0;
    if (!oob) begin
      if (rd) r.rdata = mem_m[w];
      else begin
        for (int i = 0; i < 4; i++) if (wm[i]) mem_m[w][8*i +: 8] = wd[8*i +: 8];
      end
    end
    exp_q.push_back(r);
  endfunction

  // Per-cycle comparison against the model: ready iff fewer than two responses owed.
  initial begin
    bit exp_ready;
    bit exp_valid;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (chk_on) begin
        exp_ready = (exp_q.size() < 2);
        exp_valid = (exp_q.size() != 0);
        check("cmd_ready", 32'(dtcm_cmd_ready), 32'(exp_ready));
        check("rsp_valid", 32'(dtcm_rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
          check("rsp_rdata", dtcm_rsp_rdata, exp_q[0].rdata);
`ifdef DTCM_ADDR_CHK_EN
          check("rsp_err", 32'(dtcm_rsp_err), 32'(exp_q[0].err));
`endif
          if (dtcm_rsp_ready) void'(exp_q.pop_front());
        end
        if (dtcm_cmd_valid && exp_ready)
          model_accept(dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dtcm_rsp_valid && dtcm_rsp_ready) obs_q.push_back(dtcm_rsp_rdata);
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Holds a command until accepted; returns in the cycle after the accepting edge.
  task automatic send(input logic rd, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] wm);
    bit ok = 1'b0;
    dtcm_cmd_valid = 1'b1;
    dtcm_cmd_read  = rd;
    dtcm_cmd_addr  = a;
    dtcm_cmd_wdata = wd;
    dtcm_cmd_wmask = wm;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = dtcm_cmd_ready;
      to_drive();
    end
    dtcm_cmd_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int word;
    word = $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) word += 1024 * $urandom_range(1, 15);
    return AW'(word * 4 + $urandom_range(0, 3));
  endfunction

  initial begin
    logic [AW-1:0] t4_addr [3];
    int            acc;
    t4_addr = '{16'h0020, 16'h0024, 16'h0028};

    rst            = 1'b1;
    dtcm_cmd_valid = 1'b0;
    dtcm_cmd_read  = 1'b0;
    dtcm_cmd_addr  = '0;
    dtcm_cmd_wdata = '0;
    dtcm_cmd_wmask = '0;
    dtcm_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_on = 1'b1;

    @(negedge clk);
    check("reset_cmd_ready", 32'(dtcm_cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(dtcm_rsp_valid), 32'd0);
    check("reset_rsp_rdata", dtcm_rsp_rdata, 32'h0);
    to_drive();

    for (int i = 0; i < 16; i++) send(1'b0, AW'(i * 4), 32'hC0DE0000 | i, 4'hF);

    // Full-word write then read: data one cycle after the read is accepted.
    send(1'b0, 16'h0010, 32'hDEADBEEF, 4'hF);
    send(1'b1, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_rsp_valid", 32'(dtcm_rsp_valid), 32'd1);
    check("t1_rdata", dtcm_rsp_rdata, 32'hDEADBEEF);
    to_drive();

    // Single-byte write merges into the existing word.
    send(1'b0, 16'h0010, 32'h0000AB00, 4'b0010);
    @(negedge clk);
    check("t2_wr_rsp_valid", 32'(dtcm_rsp_valid), 32'd1);
    check("t2_wr_rdata", dtcm_rsp_rdata, 32'h0);
    to_drive();
    send(1'b1, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    check("t2_rdata", dtcm_rsp_rdata, 32'hDEADABEF);
    to_drive();

    // Zero mask: response returned, memory unchanged.
    send(1'b0, 16'h0014, 32'hFFFFFFFF, 4'h0);
    @(negedge clk);
    check("wmask0_rsp_valid", 32'(dtcm_rsp_valid), 32'd1);
    to_drive();
    send(1'b1, 16'h0014, 32'h0, 4'h0);
    @(negedge clk);
    check("wmask0_rdata", dtcm_rsp_rdata, 32'hC0DE0005);
    to_drive();

    // Back-to-back reads at full throughput.
    obs_q.delete();
    dtcm_cmd_valid = 1'b1;
    dtcm_cmd_read  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dtcm_cmd_addr = AW'(i * 4);
      @(negedge clk);
      check("t3_cmd_ready", 32'(dtcm_cmd_ready), 32'd1);
      to_drive();
    end
    dtcm_cmd_valid = 1'b0;
    repeat (3) to_drive();
    check("t3_rsp_count", 32'(obs_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) check("t3_rdata", obs_q[i], 32'hC0DE0000 | i);

    // Back-pressure: two accepted, third held until the buffer drains.
    obs_q.delete();
    dtcm_rsp_ready = 1'b0;
    dtcm_cmd_valid = 1'b1;
    dtcm_cmd_read  = 1'b1;
    acc = 0;
    dtcm_cmd_addr = t4_addr[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dtcm_cmd_ready) acc++;
      to_drive();
      if (acc < 3) dtcm_cmd_addr = t4_addr[acc];
    end
    check("t4_accepted_blocked", 32'(acc), 32'd2);
    @(negedge clk);
    check("t4_cmd_ready_full", 32'(dtcm_cmd_ready), 32'd0);
    to_drive();
    dtcm_rsp_ready = 1'b1;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(negedge clk);
      if (dtcm_cmd_ready) acc++;
      to_drive();
    end
    dtcm_cmd_valid = 1'b0;
    repeat (3) to_drive();
    check("t4_accepted_total", 32'(acc), 32'd3);
    check("t4_rsp_count", 32'(obs_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) check("t4_rdata", obs_q[i], 32'hC0DE0008 | i);

    // Reset with two responses pending drops them but keeps memory.
    dtcm_rsp_ready = 1'b0;
    send(1'b1, 16'h0000, 32'h0, 4'h0);
    send(1'b1, 16'h0004, 32'h0, 4'h0);
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid", 32'(dtcm_rsp_valid), 32'd0);
    check("t5_cmd_ready", 32'(dtcm_cmd_ready), 32'd1);
    check("t5_rsp_rdata", dtcm_rsp_rdata, 32'h0);
    to_drive();
    dtcm_rsp_ready = 1'b1;
    send(1'b1, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    check("t5_rdata_kept", dtcm_rsp_rdata, 32'hDEADABEF);
    to_drive();

    // Word index 1024: rejected with range checking, aliases word 0 without it.
    send(1'b0, 16'h1000, 32'h12345678, 4'hF);
    send(1'b1, 16'h1000, 32'h0, 4'h0);
    @(negedge clk);
`ifdef DTCM_ADDR_CHK_EN
    check("t6_err", 32'(dtcm_rsp_err), 32'd1);
    check("t6_rdata", dtcm_rsp_rdata, 32'h0);
`else
    check("t6_wrap_rdata", dtcm_rsp_rdata, 32'h12345678);
`endif
    to_drive();
    send(1'b1, 16'h0000, 32'h0, 4'h0);
    @(negedge clk);
`ifdef DTCM_ADDR_CHK_EN
    check("t6_word0", dtcm_rsp_rdata, 32'hC0DE0000);
`else
    check("t6_word0_wrapped", dtcm_rsp_rdata, 32'h12345678);
`endif
    to_drive();

    // Randomized traffic with occasional resets, checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      dtcm_cmd_valid = !rst && ($urandom_range(0, 9) < 7);
      dtcm_cmd_read  = 1'($urandom_range(0, 1));
      dtcm_cmd_addr  = rand_addr();
      dtcm_cmd_wdata = $urandom;
      dtcm_cmd_wmask = 4'($urandom_range(0, 15));
      dtcm_rsp_ready = ($urandom_range(0, 3) != 0);
      to_drive();
    end
    rst            = 1'b0;
    dtcm_cmd_valid = 1'b0;
    dtcm_rsp_ready = 1'b1;
    repeat (5) to_drive();
    @(negedge clk);
    check("drained_rsp_valid", 32'(dtcm_rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
